// File: rtl/div_issue_ctrl.sv
// EX-stage issue/stall controller for the RV32M divide ops.
// Resolves div-by-zero and overflow locally, otherwise drives the divider.
module div_issue_ctrl #(
  parameter int unsigned XLEN         = 32,
  parameter int unsigned TIMEOUT      = 64,
  parameter bit          FAST_PATH_EN = 1'b1
) (
  input  logic            clk_i,
  input  logic            rst_ni,
  input  logic            ex_valid_i,
  input  logic            ex_is_div_i,
  input  logic [2:0]      ex_funct3_i,
  input  logic [XLEN-1:0] ex_rs1_i,
  input  logic [XLEN-1:0] ex_rs2_i,
  input  logic            flush_i,
  output logic            div_start_o,
  output logic [XLEN-1:0] div_a_o,
  output logic [XLEN-1:0] div_b_o,
  output logic [1:0]      div_func_o,
  input  logic            div_done_i,
  input  logic [XLEN-1:0] div_result_i,
  output logic            stall_o,
  output logic [XLEN-1:0] result_o,
  output logic            result_valid_o,
  output logic            timeout_o
);

  typedef enum logic [2:0] {
    S_IDLE,
    S_LAUNCH,
    S_WAIT,
    S_RESP,
    S_DRAIN
  } state_e;

  localparam int unsigned TW = (TIMEOUT > 1) ? $clog2(TIMEOUT) : 1;
  localparam logic [TW-1:0] TMAX =
    (TIMEOUT > 0) ? TW'(TIMEOUT - 1) : '0;
  localparam logic [XLEN-1:0] INT_MIN =
    {1'b1, {(XLEN-1){1'b0}}};

  state_e          state_q, state_d;
  logic [XLEN-1:0] a_q, a_d;
  logic [XLEN-1:0] b_q, b_d;
  logic [XLEN-1:0] res_q, res_d;
  logic [1:0]      func_q, func_d;
  logic [TW-1:0]   timer_q, timer_d;

  logic accept;
  logic b_zero;
  logic ovf;
  logic fast;
  logic wd_hit;
  logic unused_f3;

  // funct3[2] is implied by ex_is_div_i
  assign unused_f3 = ex_funct3_i[2];

  assign accept = (state_q == S_IDLE) & ex_valid_i
                & ex_is_div_i & ~flush_i;
  assign b_zero = (ex_rs2_i == '0);
  assign ovf    = ~ex_funct3_i[0] & (ex_rs1_i == INT_MIN)
                & (&ex_rs2_i);
  assign fast   = FAST_PATH_EN & (b_zero | ovf);
  assign wd_hit = (TIMEOUT != 0) & (timer_q == TMAX);

  always_comb begin
    state_d        = state_q;
    a_d            = a_q;
    b_d            = b_q;
    func_d         = func_q;
    res_d          = res_q;
    timer_d        = '0;
    div_start_o    = 1'b0;
    stall_o        = 1'b0;
    result_valid_o = 1'b0;
    timeout_o      = 1'b0;
    unique case (state_q)
      S_IDLE: begin
        if (accept) begin
          stall_o = 1'b1;
          a_d     = ex_rs1_i;
          b_d     = ex_rs2_i;
          func_d  = ex_funct3_i[1:0];
          if (fast) begin
            state_d = S_RESP;
            if (b_zero)
              res_d = ex_funct3_i[1] ? ex_rs1_i : '1;
            else
              res_d = ex_funct3_i[1] ? '0 : INT_MIN;
          end else begin
            state_d = S_LAUNCH;
          end
        end
      end
      S_LAUNCH: begin
        stall_o     = 1'b1;
        div_start_o = 1'b1;
        state_d     = flush_i ? S_DRAIN : S_WAIT;
      end
      S_WAIT: begin
        stall_o = 1'b1;
        timer_d = timer_q + 1'b1;
        if (div_done_i) begin
          res_d   = div_result_i;
          state_d = S_RESP;
        end else if (flush_i) begin
          state_d = S_DRAIN;
        end else if (wd_hit) begin
          timeout_o = 1'b1;
          res_d     = '1;
          state_d   = S_RESP;
        end
      end
      S_RESP: begin
        result_valid_o = ~flush_i;
        state_d        = S_IDLE;
      end
      S_DRAIN: begin
        // hold off a new divide until the old result is gone
        stall_o = ex_valid_i & ex_is_div_i;
        timer_d = timer_q + 1'b1;
        if (div_done_i | wd_hit)
          state_d = S_IDLE;
      end
      default: state_d = S_IDLE;
    endcase
  end

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      state_q <= S_IDLE;
      a_q     <= '0;
      b_q     <= '0;
      func_q  <= '0;
      res_q   <= '0;
      timer_q <= '0;
    end else begin
      state_q <= state_d;
      a_q     <= a_d;
      b_q     <= b_d;
      func_q  <= func_d;
      res_q   <= res_d;
      timer_q <= timer_d;
    end
  end

  assign div_a_o    = a_q;
  assign div_b_o    = b_q;
  assign div_func_o = func_q;
  assign result_o   = res_q;

endmodule

// File: tb/tb_div_issue_ctrl.sv
// Directed bench for div_issue_ctrl with a 3-cycle divider model.
// Watchdog shortened to 8 cycles so the abort path is reachable.
module tb_div_issue_ctrl;

  logic        clk = 1'b0;
  logic        rst_ni = 1'b0;
  logic        ex_valid_i = 1'b0;
  logic        ex_is_div_i = 1'b0;
  logic [2:0]  ex_funct3_i = '0;
  logic [31:0] ex_rs1_i = '0;
  logic [31:0] ex_rs2_i = '0;
  logic        flush_i = 1'b0;
  logic        div_start_o;
  logic [31:0] div_a_o, div_b_o;
  logic [1:0]  div_func_o;
  logic        div_done_i;
  logic [31:0] div_result_i;
  logic        stall_o;
  logic [31:0] result_o;
  logic        result_valid_o;
  logic        timeout_o;

  int   checks = 0;
  int   errs = 0;
  logic hang = 1'b0;
  logic d1, d2;

  always #5 clk = ~clk;

  div_issue_ctrl #(
    .XLEN(32), .TIMEOUT(8), .FAST_PATH_EN(1'b1)
  ) dut (
    .clk_i(clk), .rst_ni(rst_ni),
    .ex_valid_i(ex_valid_i), .ex_is_div_i(ex_is_div_i),
    .ex_funct3_i(ex_funct3_i),
    .ex_rs1_i(ex_rs1_i), .ex_rs2_i(ex_rs2_i),
    .flush_i(flush_i),
    .div_start_o(div_start_o),
    .div_a_o(div_a_o), .div_b_o(div_b_o),
    .div_func_o(div_func_o),
    .div_done_i(div_done_i), .div_result_i(div_result_i),
    .stall_o(stall_o), .result_o(result_o),
    .result_valid_o(result_valid_o),
    .timeout_o(timeout_o)
  );

  function automatic logic [31:0] ref_div(
    input logic [31:0] a, input logic [31:0] b,
    input logic [1:0] f);
    if (b == 0 || (a == 32'h8000_0000 && b == '1))
      return 32'hDEAD_BEEF;
    case (f)
      2'b00:   return $signed(a) / $signed(b);
      2'b01:   return a / b;
      2'b10:   return $signed(a) % $signed(b);
      default: return a % b;
    endcase
  endfunction

  // divider: start in cycle n, done in cycle n+2
  always @(posedge clk or negedge rst_ni) begin
    if (!rst_ni) begin
      d1 <= 1'b0;
      d2 <= 1'b0;
    end else begin
      d1 <= div_start_o & ~hang;
      d2 <= d1;
    end
  end
  assign div_done_i = d2;
  always_comb div_result_i = ref_div(div_a_o, div_b_o, div_func_o);

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic drive(input logic [2:0] f3,
                       input logic [31:0] a,
                       input logic [31:0] b);
    ex_valid_i  = 1'b1;
    ex_is_div_i = 1'b1;
    ex_funct3_i = f3;
    ex_rs1_i    = a;
    ex_rs2_i    = b;
  endtask

  task automatic test_reset();
    #2;
    if ({stall_o, div_start_o, result_valid_o, timeout_o} !== 4'b0) begin
      errs++;
      $display("FAIL rst_ctl got %b exp 0000",
        {stall_o, div_start_o, result_valid_o, timeout_o});
    end
    checks++;
    if ({div_a_o, div_b_o, result_o} !== 96'b0) begin
      errs++;
      $display("FAIL rst_data got %h %h %h exp 0",
        div_a_o, div_b_o, result_o);
    end
    checks++;
    if (div_func_o !== 2'b00) begin
      errs++;
      $display("FAIL rst_func got %b exp 00", div_func_o);
    end
    checks++;
    @(negedge clk);
    #2 rst_ni = 1'b1;
    tick();
  endtask

  task automatic test_div_latency();
    logic es, ep, ev;
    drive(3'b100, 32'd15, 32'd7);
    for (int c = 0; c < 6; c++) begin
      @(negedge clk);
      es = (c <= 3);
      ep = (c == 1);
      ev = (c == 4);
      if (stall_o !== es) begin
        errs++;
        $display("FAIL lat_stall c%0d got %b exp %b", c, stall_o, es);
      end
      checks++;
      if (div_start_o !== ep) begin
        errs++;
        $display("FAIL lat_start c%0d got %b exp %b", c, div_start_o, ep);
      end
      checks++;
      if (result_valid_o !== ev) begin
        errs++;
        $display("FAIL lat_valid c%0d got %b exp %b",
          c, result_valid_o, ev);
      end
      checks++;
      if (c == 4) begin
        if (result_o !== 32'd2) begin
          errs++;
          $display("FAIL lat_result got %h exp 2", result_o);
        end
        checks++;
      end
      tick();
      if (c == 0) ex_valid_i = 1'b0;
    end
  endtask

  task automatic test_rem_hold();
    drive(3'b110, 32'hFFFF_FFF1, 32'd4);
    for (int c = 0; c < 6; c++) begin
      @(negedge clk);
      if (c == 2 || c == 3) begin
        if (div_func_o !== 2'b10 || div_a_o !== 32'hFFFF_FFF1
            || div_b_o !== 32'd4) begin
          errs++;
          $display("FAIL rem_hold c%0d got %b %h %h exp 10 fffffff1 4",
            c, div_func_o, div_a_o, div_b_o);
        end
        checks++;
      end
      if (c == 4) begin
        if (result_valid_o !== 1'b1 || result_o !== 32'hFFFF_FFFD) begin
          errs++;
          $display("FAIL rem_result got %b %h exp 1 fffffffd",
            result_valid_o, result_o);
        end
        checks++;
      end
      tick();
      if (c == 0) ex_valid_i = 1'b0;
    end
  endtask

  task automatic test_fast_path();
    logic [2:0]  fv[5];
    logic [31:0] av[5];
    logic [31:0] bv[5];
    logic [31:0] ev[5];
    fv = '{3'b101, 3'b111, 3'b100, 3'b110, 3'b100};
    av = '{32'd5, 32'd5, 32'h8000_0000, 32'h8000_0000, 32'd7};
    bv = '{32'd0, 32'd0, 32'hFFFF_FFFF, 32'hFFFF_FFFF, 32'd0};
    ev = '{32'hFFFF_FFFF, 32'd5, 32'h8000_0000, 32'd0, 32'hFFFF_FFFF};
    for (int i = 0; i < 5; i++) begin
      drive(fv[i], av[i], bv[i]);
      @(negedge clk);
      if (stall_o !== 1'b1 || div_start_o !== 1'b0) begin
        errs++;
        $display("FAIL fast_acc v%0d got %b%b exp 10",
          i, stall_o, div_start_o);
      end
      checks++;
      tick();
      ex_valid_i = 1'b0;
      @(negedge clk);
      if (stall_o !== 1'b0 || div_start_o !== 1'b0
          || result_valid_o !== 1'b1) begin
        errs++;
        $display("FAIL fast_resp v%0d got %b%b%b exp 001",
          i, stall_o, div_start_o, result_valid_o);
      end
      checks++;
      if (result_o !== ev[i]) begin
        errs++;
        $display("FAIL fast_result v%0d got %h exp %h",
          i, result_o, ev[i]);
      end
      checks++;
      tick();
      @(negedge clk);
      if (result_valid_o !== 1'b0 || div_start_o !== 1'b0) begin
        errs++;
        $display("FAIL fast_idle v%0d got %b%b exp 00",
          i, result_valid_o, div_start_o);
      end
      checks++;
      tick();
    end
  endtask

  task automatic test_flush_drain();
    drive(3'b100, 32'd20, 32'd3);
    tick();
    ex_valid_i = 1'b0;
    tick();
    flush_i = 1'b1;
    @(negedge clk);
    if (stall_o !== 1'b1) begin
      errs++;
      $display("FAIL fl_wait_stall got %b exp 1", stall_o);
    end
    checks++;
    tick();
    flush_i = 1'b0;
    @(negedge clk);
    if ({stall_o, result_valid_o, div_start_o} !== 3'b000) begin
      errs++;
      $display("FAIL fl_drain got %b exp 000",
        {stall_o, result_valid_o, div_start_o});
    end
    checks++;
    tick();
    @(negedge clk);
    if ({stall_o, result_valid_o} !== 2'b00) begin
      errs++;
      $display("FAIL fl_idle got %b exp 00", {stall_o, result_valid_o});
    end
    checks++;
    tick();
    // second pass: a new divide arrives while draining
    drive(3'b100, 32'd20, 32'd3);
    tick();
    ex_valid_i = 1'b0;
    tick();
    flush_i = 1'b1;
    tick();
    flush_i = 1'b0;
    drive(3'b101, 32'd100, 32'd7);
    @(negedge clk);
    if ({stall_o, div_start_o, result_valid_o} !== 3'b100) begin
      errs++;
      $display("FAIL dr_new_stall got %b exp 100",
        {stall_o, div_start_o, result_valid_o});
    end
    checks++;
    if (div_a_o !== 32'd20) begin
      errs++;
      $display("FAIL dr_hold_a got %h exp 14", div_a_o);
    end
    checks++;
    tick();
    @(negedge clk);
    if ({stall_o, div_start_o} !== 2'b10) begin
      errs++;
      $display("FAIL dr_accept got %b exp 10", {stall_o, div_start_o});
    end
    checks++;
    tick();
    ex_valid_i = 1'b0;
    @(negedge clk);
    if (div_start_o !== 1'b1) begin
      errs++;
      $display("FAIL dr_launch got %b exp 1", div_start_o);
    end
    checks++;
    tick();
    tick();
    tick();
    @(negedge clk);
    if (result_valid_o !== 1'b1 || result_o !== 32'd14) begin
      errs++;
      $display("FAIL dr_result got %b %h exp 1 e",
        result_valid_o, result_o);
    end
    checks++;
    tick();
  endtask

  task automatic test_timeout();
    logic es, et, ev;
    hang = 1'b1;
    drive(3'b100, 32'd9, 32'd2);
    for (int c = 0; c < 12; c++) begin
      @(negedge clk);
      es = (c <= 9);
      et = (c == 9);
      ev = (c == 10);
      if ({stall_o, timeout_o, result_valid_o} !== {es, et, ev}) begin
        errs++;
        $display("FAIL to_ctl c%0d got %b exp %b", c,
          {stall_o, timeout_o, result_valid_o}, {es, et, ev});
      end
      checks++;
      if (c == 10) begin
        if (result_o !== 32'hFFFF_FFFF) begin
          errs++;
          $display("FAIL to_result got %h exp ffffffff", result_o);
        end
        checks++;
      end
      tick();
      if (c == 0) ex_valid_i = 1'b0;
    end
    hang = 1'b0;
  endtask

  task automatic test_reset_mid();
    drive(3'b100, 32'd15, 32'd7);
    tick();
    ex_valid_i = 1'b0;
    tick();
    #2 rst_ni = 1'b0;
    #1;
    if ({stall_o, div_start_o, result_valid_o, timeout_o} !== 4'b0) begin
      errs++;
      $display("FAIL rm_ctl got %b exp 0000",
        {stall_o, div_start_o, result_valid_o, timeout_o});
    end
    checks++;
    if ({div_a_o, div_b_o, result_o} !== 96'b0
        || div_func_o !== 2'b00) begin
      errs++;
      $display("FAIL rm_data got %h %h %h %b exp 0",
        div_a_o, div_b_o, result_o, div_func_o);
    end
    checks++;
    @(negedge clk);
    rst_ni = 1'b1;
    tick();
    drive(3'b100, 32'd15, 32'd7);
    for (int c = 0; c < 5; c++) begin
      @(negedge clk);
      if (c == 1 && div_start_o !== 1'b1) begin
        errs++;
        $display("FAIL rm_start got %b exp 1", div_start_o);
      end
      if (c == 1) checks++;
      if (c == 4) begin
        if (result_valid_o !== 1'b1 || result_o !== 32'd2
            || stall_o !== 1'b0) begin
          errs++;
          $display("FAIL rm_result got %b %h %b exp 1 2 0",
            result_valid_o, result_o, stall_o);
        end
        checks++;
      end
      tick();
      if (c == 0) ex_valid_i = 1'b0;
    end
  endtask

  initial begin
    test_reset();
    test_div_latency();
    test_rem_hold();
    test_fast_path();
    test_flush_drain();
    test_timeout();
    test_reset_mid();
    $display("CHECKS %0d ERRORS %0d", checks, errs);
    $finish;
  end

  initial begin
    #100000;
    $display("FAIL sim_watchdog got hang exp finish");
    $fatal(1);
  end

endmodule
